acc_alu_unit: RTL and testbench
===============================

ACC_ALU_UNIT -- requirements
Module: acc_alu_unit

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set datapath width of accumulator, operand register and data_in (legal range 4-32).
REQ-002 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 RESET  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 HLT  input  1  SHALL freeze all internal state while high.
REQ-005 A_load  input  1  SHALL load data_in into the accumulator.
REQ-006 B_load  input  1  SHALL load data_in into the operand register B.
REQ-007 exec  input  1  SHALL request one ALU operation ACC <= ACC op B.
REQ-008 op  input  4  SHALL select the operation sampled with exec.
REQ-009 data_in  input  WIDTH  SHALL be the shared load bus.
REQ-010 A_out  output  WIDTH  SHALL present the accumulator register.
REQ-011 c_out, z_out, n_out, v_out  output  1 each  SHALL present the carry, zero, negative and overflow flag registers.
REQ-012 done  output  1  SHALL pulse high for one cycle after each executed operation.

Function
REQ-013 Operation codes SHALL be: 0000 ADD, 0001 SUB, 0010 ADC, 0011 SBB, 0100 AND, 0101 OR, 0110 XOR, 0111 PASSB.
REQ-014 ADD/ADC SHALL compute ACC+B(+C); SUB/SBB SHALL compute ACC+~B+1 (SBB: ACC+~B+C); C = carry out of bit WIDTH-1 (SUB: C=1 means no borrow).
REQ-015 V SHALL be set on signed overflow for arithmetic ops and cleared for logic ops and PASSB; C SHALL be cleared for logic ops and PASSB.
REQ-016 Z SHALL be set when the WIDTH-bit result is all zeros; N SHALL equal result bit WIDTH-1; both updated by every executed op.
REQ-017 Flags SHALL change only on executed ops; A_load and B_load SHALL leave flags unchanged.
REQ-018 Result SHALL appear on A_out and flags one edge after exec is sampled high; done SHALL be high during the following cycle only.
REQ-019 Priority per edge: HLT > A_load > exec; A_load with exec SHALL load ACC, drop the op, and keep done low.
REQ-020 B_load with exec SHALL use the old B for the op and update B on the same edge.
REQ-021 While HLT is high, ACC, B, flags SHALL hold, all requests SHALL be discarded (not queued) and done SHALL be low.
REQ-022 Back-to-back exec on consecutive cycles SHALL chain, each using the previous result; done SHALL stay high continuously.
REQ-023 Arithmetic SHALL wrap modulo 2^WIDTH.

Reset
REQ-024 RESET high SHALL immediately clear ACC, B, C, Z, N, V and done to 0, independent of CLK.
REQ-025 RESET asserted mid-operation SHALL discard the pending result; the first edge after deassertion SHALL act on sampled inputs normally.

Configuration
REQ-026 Macro ACC_ALU_SHIFT_EN defined SHALL add 1000 SHL (ACC<<1, C = old bit WIDTH-1) and 1001 SHR (logical ACC>>1, C = old bit 0), V cleared, Z/N from result.
REQ-027 Without ACC_ALU_SHIFT_EN, codes 1000-1111 SHALL be NOPs: ACC and flags unchanged, done still pulses; with it, 1010-1111 SHALL be NOPs.

Verification (WIDTH=8)
REQ-028 Load A=0x7F, B=0x01, exec ADD -> A_out=0x80, C=0, Z=0, N=1, V=1, done high one cycle later.
REQ-029 A=0x05, B=0x05, exec SUB -> A_out=0x00, C=1, Z=1, V=0; then exec SBB -> A_out=0x00-0x05+1-1=0xFB, C=0, N=1.
REQ-030 A=0xFF, B=0x01, exec ADD then ADC back-to-back -> 0x00 (C=1, Z=1), then 0x02 (C=0); done high two consecutive cycles.
REQ-031 A=0x3C, HLT high with exec ADD and A_load asserted three cycles -> A_out stays 0x3C, done low; A_load and exec same edge -> ACC=data_in, flags unchanged, no done.
REQ-032 RESET pulsed between exec edge and done -> A_out, flags, done all 0 asynchronously, no done pulse.
REQ-033 A=0x81, op 1000: with ACC_ALU_SHIFT_EN -> A_out=0x02, C=1; without -> A_out=0x81, flags unchanged, done pulses.

Source files
------------

// File: rtl/acc_alu_unit.sv
// Accumulator ALU: ACC <= ACC op B with C/Z/N/V flag registers, load bus, halt and done pulse.
// Optional macro ACC_ALU_SHIFT_EN adds SHL (1000) and SHR (1001); otherwise codes 1000-1111 are NOPs.
module acc_alu_unit #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             HLT,
    input  logic             A_load,
    input  logic             B_load,
    input  logic             exec,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] A_out,
    output logic             c_out,
    output logic             z_out,
    output logic             n_out,
    output logic             v_out,
    output logic             done
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_ADC   = 4'b0010;
    localparam logic [3:0] OP_SBB   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
`ifdef ACC_ALU_SHIFT_EN
    localparam logic [3:0] OP_SHL   = 4'b1000;
    localparam logic [3:0] OP_SHR   = 4'b1001;
`endif

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             v_q, v_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] b_eff_s;
    logic             cin_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] res_s;
    logic             res_c_s;
    logic             res_v_s;
    logic             op_valid_s;

    // Adder operand selection: subtraction is ACC + ~B + carry-in.
    always_comb begin
        b_eff_s = b_q;
        cin_s   = 1'b0;
        case (op)
            OP_ADD: begin
                b_eff_s = b_q;
                cin_s   = 1'b0;
            end
            OP_ADC: begin
                b_eff_s = b_q;
                cin_s   = c_q;
            end
            OP_SUB: begin
                b_eff_s = ~b_q;
                cin_s   = 1'b1;
            end
            OP_SBB: begin
                b_eff_s = ~b_q;
                cin_s   = c_q;
            end
            default: begin
                b_eff_s = b_q;
                cin_s   = 1'b0;
            end
        endcase
        sum_s = {1'b0, acc_q} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
    end

    // Result and carry/overflow for the selected operation; NOP codes leave op_valid_s low.
    always_comb begin
        res_s      = acc_q;
        res_c_s    = c_q;
        res_v_s    = v_q;
        op_valid_s = 1'b0;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
                res_s      = sum_s[WIDTH-1:0];
                res_c_s    = sum_s[WIDTH];
                res_v_s    = (acc_q[WIDTH-1] == b_eff_s[WIDTH-1]) &&
                             (sum_s[WIDTH-1] != acc_q[WIDTH-1]);
                op_valid_s = 1'b1;
            end
            OP_AND: begin
                res_s      = acc_q & b_q;
                res_c_s    = 1'b0;
                res_v_s    = 1'b0;
                op_valid_s = 1'b1;
            end
            OP_OR: begin
                res_s      = acc_q | b_q;
                res_c_s    = 1'b0;
                res_v_s    = 1'b0;
                op_valid_s = 1'b1;
            end
            OP_XOR: begin
                res_s      = acc_q ^ b_q;
                res_c_s    = 1'b0;
                res_v_s    = 1'b0;
                op_valid_s = 1'b1;
            end
            OP_PASSB: begin
                res_s      = b_q;
                res_c_s    = 1'b0;
                res_v_s    = 1'b0;
                op_valid_s = 1'b1;
            end
`ifdef ACC_ALU_SHIFT_EN
            OP_SHL: begin
                res_s      = {acc_q[WIDTH-2:0], 1'b0};
                res_c_s    = acc_q[WIDTH-1];
                res_v_s    = 1'b0;
                op_valid_s = 1'b1;
            end
            OP_SHR: begin
                res_s      = {1'b0, acc_q[WIDTH-1:1]};
                res_c_s    = acc_q[0];
                res_v_s    = 1'b0;
                op_valid_s = 1'b1;
            end
`endif
            default: begin
                res_s      = acc_q;
                res_c_s    = c_q;
                res_v_s    = v_q;
                op_valid_s = 1'b0;
            end
        endcase
    end

    // Next state: HLT freezes everything, A_load beats exec, B_load updates B after the op reads it.
    always_comb begin
        acc_d  = acc_q;
        b_d    = b_q;
        c_d    = c_q;
        z_d    = z_q;
        n_d    = n_q;
        v_d    = v_q;
        done_d = 1'b0;
        if (HLT) begin
            done_d = 1'b0;
        end else begin
            if (B_load) begin
                b_d = data_in;
            end else begin
                b_d = b_q;
            end
            if (A_load) begin
                acc_d = data_in;
            end else if (exec) begin
                done_d = 1'b1;
                if (op_valid_s) begin
                    acc_d = res_s;
                    c_d   = res_c_s;
                    z_d   = (res_s == {WIDTH{1'b0}});
                    n_d   = res_s[WIDTH-1];
                    v_d   = res_v_s;
                end else begin
                    acc_d = acc_q;
                end
            end else begin
                done_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc_q  <= {WIDTH{1'b0}};
            b_q    <= {WIDTH{1'b0}};
            c_q    <= 1'b0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            v_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            b_q    <= b_d;
            c_q    <= c_d;
            z_q    <= z_d;
            n_q    <= n_d;
            v_q    <= v_d;
            done_q <= done_d;
        end
    end

    assign A_out = acc_q;
    assign c_out = c_q;
    assign z_out = z_q;
    assign n_out = n_q;
    assign v_out = v_q;
    assign done  = done_q;

endmodule

// File: tb/tb_acc_alu_unit.sv
// Scoreboard bench for acc_alu_unit (WIDTH=8): directed scenarios then random stimulus vs. an arithmetic reference model.
module tb_acc_alu_unit;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         HLT = 1'b0;
    logic         A_load = 1'b0;
    logic         B_load = 1'b0;
    logic         exec = 1'b0;
    logic [3:0]   op = 4'b0000;
    logic [W-1:0] data_in = 8'h00;
    logic [W-1:0] A_out;
    logic         c_out, z_out, n_out, v_out, done;

    acc_alu_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .HLT(HLT), .A_load(A_load), .B_load(B_load),
        .exec(exec), .op(op), .data_in(data_in), .A_out(A_out),
        .c_out(c_out), .z_out(z_out), .n_out(n_out), .v_out(v_out), .done(done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] acc;
        logic [3:0] fl;
        logic       dn;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int m_acc = 0, m_b = 0;
    bit mc = 0, mz = 0, mn = 0, mv = 0, md = 0;

    function automatic int sgn(int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_b = 0; mc = 0; mz = 0; mn = 0; mv = 0; md = 0;
    endtask

    task automatic model_step(bit hlt, bit al, bit bl, bit ex, int o, int d);
        int  a, b, full, sres, res, new_b;
        bit  cin, upd;
        if (hlt) begin
            md = 0;
            return;
        end
        new_b = bl ? d : m_b;
        if (al) begin
            m_acc = d;
            md = 0;
        end else if (ex) begin
            md = 1; a = m_acc; b = m_b; cin = mc; upd = 1; res = a;
            case (o)
                0: begin full = a + b; res = full & 255; mc = (full > 255); sres = sgn(a) + sgn(b); mv = (sres > 127 || sres < -128); end
                2: begin full = a + b + int'(cin); res = full & 255; mc = (full > 255); sres = sgn(a) + sgn(b) + int'(cin); mv = (sres > 127 || sres < -128); end
                1: begin full = a - b; res = full & 255; mc = (full >= 0); sres = sgn(a) - sgn(b); mv = (sres > 127 || sres < -128); end
                3: begin full = a - b - (1 - int'(cin)); res = full & 255; mc = (full >= 0); sres = sgn(a) - sgn(b) - (1 - int'(cin)); mv = (sres > 127 || sres < -128); end
                4: begin res = a & b; mc = 0; mv = 0; end
                5: begin res = a | b; mc = 0; mv = 0; end
                6: begin res = a ^ b; mc = 0; mv = 0; end
                7: begin res = b; mc = 0; mv = 0; end
`ifdef ACC_ALU_SHIFT_EN
                8: begin res = (a * 2) & 255; mc = (a >= 128); mv = 0; end
                9: begin res = a / 2; mc = (a % 2 == 1); mv = 0; end
`endif
                default: upd = 0;
            endcase
            if (upd) begin
                m_acc = res;
                mz = (res == 0);
                mn = (res >= 128);
            end
        end else begin
            md = 0;
        end
        m_b = new_b;
    endtask

    task automatic drive(bit hlt, bit al, bit bl, bit ex, int o, int d);
        exp_t e;
        @(negedge CLK);
        HLT = hlt; A_load = al; B_load = bl; exec = ex;
        op = o[3:0]; data_in = d[7:0];
        model_step(hlt, al, bl, ex, o, d);
        e.acc = m_acc[7:0];
        e.fl  = {mc, mz, mn, mv};
        e.dn  = md;
        exp_q.push_back(e);
    endtask

    task automatic check_now(string nm, logic [7:0] ea, logic [3:0] ef, logic [3:0] fm, logic ed);
        logic [3:0] fl;
        @(posedge CLK);
        #3;
        fl = {c_out, z_out, n_out, v_out};
        n_cmp++;
        if (A_out !== ea || (fl & fm) !== (ef & fm) || done !== ed) begin
            n_bad++;
            $display("FAIL %s: got acc=%h cznv=%b done=%b, want acc=%h cznv=%b (mask %b) done=%b",
                     nm, A_out, fl, done, ea, ef, fm, ed);
        end
    endtask

    task automatic check_zero(string nm);
        n_cmp++;
        if (A_out !== 8'h00 || {c_out, z_out, n_out, v_out} !== 4'b0000 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got acc=%h cznv=%b done=%b, want all zero",
                     nm, A_out, {c_out, z_out, n_out, v_out}, done);
        end
    endtask

    // Scoreboard monitor: one expected record per clock edge that followed a drive.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (A_out !== e.acc || {c_out, z_out, n_out, v_out} !== e.fl || done !== e.dn) begin
                    n_bad++;
                    $display("FAIL scoreboard @%0t: got acc=%h cznv=%b done=%b, want acc=%h cznv=%b done=%b",
                             $time, A_out, {c_out, z_out, n_out, v_out}, done, e.acc, e.fl, e.dn);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1;
        check_zero("reset_state");
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();

        // 0x7F + 0x01 signed overflow
        drive(0, 1, 0, 0, 0, 8'h7F);
        drive(0, 0, 1, 0, 0, 8'h01);
        drive(0, 0, 0, 1, 0, 0);
        check_now("add_ovf", 8'h80, 4'b0011, 4'b1111, 1'b1);
        drive(0, 0, 0, 0, 0, 0);
        check_now("done_one_cycle", 8'h80, 4'b0011, 4'b1111, 1'b0);

        // SUB to zero, then SBB using the no-borrow carry
        drive(0, 1, 1, 0, 0, 8'h05);
        drive(0, 0, 0, 1, 1, 0);
        check_now("sub_zero", 8'h00, 4'b1100, 4'b1111, 1'b1);
        drive(0, 0, 0, 1, 3, 0);
        check_now("sbb", 8'hFB, 4'b0010, 4'b1111, 1'b1);

        // Back-to-back ADD, ADC chain
        drive(0, 1, 0, 0, 0, 8'hFF);
        drive(0, 0, 1, 0, 0, 8'h01);
        drive(0, 0, 0, 1, 0, 0);
        check_now("chain_add", 8'h00, 4'b1100, 4'b1111, 1'b1);
        drive(0, 0, 0, 1, 2, 0);
        check_now("chain_adc", 8'h02, 4'b0000, 4'b1111, 1'b1);

        // HLT discards loads and exec; A_load beats exec
        drive(0, 1, 0, 0, 0, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, 0, 8'h55);
            check_now("hlt_hold", 8'h3C, 4'b0000, 4'b1111, 1'b0);
        end
        drive(0, 1, 0, 1, 0, 8'h99);
        check_now("aload_beats_exec", 8'h99, 4'b0000, 4'b1111, 1'b0);

        // Asynchronous reset between the exec edge and the done cycle
        drive(0, 1, 0, 0, 0, 8'h10);
        drive(0, 0, 1, 0, 0, 8'h20);
        drive(0, 0, 0, 1, 0, 0);
        @(posedge CLK);
        #3 RESET = 1'b1;
        #1 check_zero("async_reset");
        RESET = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        check_now("post_reset_idle", 8'h00, 4'b0000, 4'b1111, 1'b0);

        // Code 1000: SHL when enabled, NOP otherwise
        drive(0, 1, 0, 0, 0, 8'h81);
        drive(0, 0, 0, 1, 8, 0);
`ifdef ACC_ALU_SHIFT_EN
        check_now("op1000_shl", 8'h02, 4'b1000, 4'b1111, 1'b1);
`else
        check_now("op1000_nop", 8'h81, 4'b0000, 4'b1111, 1'b1);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
        end
        drive(0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #4;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
